// File: rtl/timer_bank_if.sv
// timer_bank_if: host-side control/status bundle for a timer_bank instance.
// The host drives the channel controls and period writes (master); the
// timer bank returns done pulses, run status and the interrupt state (slave).
interface timer_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] pause;
    logic [NUM_CH-1:0] periodic;
    logic              load_en;
    logic [LCH_W-1:0]  load_ch;
    logic [CNT_W-1:0]  load_val;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] irq_clr;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] irq_flag;
    logic              irq;

    modport master (
        output start, stop, pause, periodic, load_en, load_ch, load_val, irq_en, irq_clr,
        input  done, running, irq_flag, irq
    );

    modport slave (
        input  start, stop, pause, periodic, load_en, load_ch, load_val, irq_en, irq_clr,
        output done, running, irq_flag, irq
    );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent interval timers (one-shot / periodic) with
// pause, abort and sticky maskable interrupt flags.
// Optional feature: define TIMER_BANK_PRESCALE_EN to count only on a shared
// prescaler tick every PRESCALE clocks; otherwise every clock is a tick.
module timer_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 49_999_999,
    parameter int unsigned PRESCALE       = 50
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_bank_if.slave  bus
);
    localparam int unsigned LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("timer_bank: NUM_CH must be in 1..16");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("timer_bank: PRESCALE must be at least 1");
    end

    state_e                       state_q [NUM_CH];
    state_e                       state_d [NUM_CH];
    logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
    logic [NUM_CH-1:0][CNT_W-1:0] term_q, term_d;
    logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d;
    logic [NUM_CH-1:0]            mode_q, mode_d;
    logic [NUM_CH-1:0]            done_q, done_d;
    logic [NUM_CH-1:0]            running_q, running_d;
    logic [NUM_CH-1:0]            flag_q, flag_d;
    logic                         tick_c;

`ifdef TIMER_BANK_PRESCALE_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;

    // Shared free-running divider; tick on its last count.
    always_comb begin
        tick_c = (pre_q == PRE_W'(PRESCALE - 1));
        pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end
`else
    assign tick_c = 1'b1;
`endif

    // Per-channel next state: stop > start > terminal count > pause.
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        term_d    = term_q;
        count_d   = count_q;
        mode_d    = mode_q;
        done_d    = '0;
        running_d = running_q;
        flag_d    = flag_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.load_en && (bus.load_ch == LCH_W'(i))) begin
                period_d[i] = bus.load_val;
            end
            if (bus.stop[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (bus.start[i]) begin
                state_d[i] = ST_RUN;
                count_d[i] = '0;
                term_d[i]  = period_q[i];
                mode_d[i]  = bus.periodic[i];
            end else begin
                case (state_q[i])
                    ST_RUN, ST_PAUSED: begin
                        // A paused channel only reaches terminal count on the resume cycle.
                        if (tick_c && (count_q[i] == term_q[i]) &&
                            ((state_q[i] == ST_RUN) || !bus.pause[i])) begin
                            done_d[i]  = 1'b1;
                            count_d[i] = '0;
                            if (mode_q[i]) begin
                                state_d[i] = ST_RUN;
                                term_d[i]  = period_q[i];
                                mode_d[i]  = bus.periodic[i];
                            end else begin
                                state_d[i] = ST_IDLE;
                            end
                        end else if (bus.pause[i]) begin
                            state_d[i] = ST_PAUSED;
                        end else begin
                            // Resume counts on the same tick so a pause costs exactly its length.
                            state_d[i] = ST_RUN;
                            if (tick_c) count_d[i] = count_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        count_d[i] = '0;
                    end
                endcase
            end
            running_d[i] = (state_d[i] != ST_IDLE);
            // Flag is also re-set during the done cycle, so a clear there loses.
            flag_d[i] = (flag_q[i] & ~bus.irq_clr[i]) | done_d[i] | done_q[i];
        end
    end

    // Channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
            period_q  <= {NUM_CH{CNT_W'(DEFAULT_PERIOD)}};
            term_q    <= {NUM_CH{CNT_W'(DEFAULT_PERIOD)}};
            count_q   <= '0;
            mode_q    <= '0;
            done_q    <= '0;
            running_q <= '0;
            flag_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
            period_q  <= period_d;
            term_q    <= term_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            running_q <= running_d;
            flag_q    <= flag_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.running  = running_q;
    assign bus.irq_flag = flag_q;
    assign bus.irq      = |(flag_q & bus.irq_en);

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel programmable interval timer bank. Each of `NUM_CH` independent channels counts against a software-loadable period and supports one-shot or periodic operation, pause/resume, abort, and a sticky, maskable interrupt flag. It is the general-purpose timing resource for the control FSMs and the processor-visible interrupt path.

## Interface
- `NUM_CH`, 4, number of timer channels (1–16)
- `CNT_W`, 32, counter and period width in bits
- `DEFAULT_PERIOD`, 49_999_999, reset value of every channel's period register (1 s at 50 MHz)
- `PRESCALE`, 50, tick divider; used only when `TIMER_BANK_PRESCALE_EN` is defined
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in NUM_CH: per-channel start/restart pulse
- `stop` in NUM_CH: per-channel abort pulse
- `pause` in NUM_CH: per-channel level hold
- `periodic` in NUM_CH: per-channel mode, 1 = auto-reload, 0 = one-shot; sampled at start and at each terminal count
- `load_en` in 1: period write strobe
- `load_ch` in $clog2(NUM_CH) (min 1): channel index for the write
- `load_val` in CNT_W: new period value
- `irq_en` in NUM_CH: interrupt mask
- `irq_clr` in NUM_CH: write-one-to-clear for the sticky flags
- `done` out NUM_CH: registered one-cycle pulse at terminal count
- `running` out NUM_CH: high in RUN or PAUSED
- `irq_flag` out NUM_CH: sticky per-channel done flags
- `irq` out 1: OR of (`irq_flag` & `irq_en`), combinational from registers

## Operation
- Each channel holds registers `period`, `term` (latched terminal value), `count`, `mode`, and state {IDLE, RUN, PAUSED}.
- Period load: on `load_en`, `period[load_ch] <= load_val`. An out-of-range `load_ch` is ignored. A load never disturbs the current run; `term` picks up the new value at the next start or reload.
- Priority per channel: `stop` > `start` > terminal count > `pause`.
- `stop` (any state): go to IDLE, `count <= 0`. No `done` is produced, and a terminal count in the same cycle is suppressed.
- `start` (any state, no stop): go to RUN, `count <= 0`, `term <= period`, `mode <= periodic`. A start during RUN or PAUSED restarts the channel.
- RUN: `count <= count + 1` each tick. When `count == term` on a tick:
  - `done` is registered high for the next cycle.
  - `count <= 0`.
  - If `mode` is set, stay in RUN and relatch `term <= period` and `mode <= periodic`.
  - Otherwise go to IDLE.
- RUN with `pause`=1 and no terminal count: go to PAUSED with `count` held. A terminal count takes priority over a pause in the same cycle.
- PAUSED with `pause`=0: return to RUN. Counting resumes on the next tick.
- IDLE: `count` is held at 0. `pause` is ignored.
- `irq_flag[i]` is set on the `done[i]` pulse and cleared by `irq_clr[i]`. If set and clear occur in the same cycle, set wins.
- `count` never exceeds `term`, so there is no wrap-around. With `period = 0`, periodic mode produces `done` on every tick.

## Timing
- Reset values:
  - all channels in IDLE, `count` = 0, `term` = `period` = `DEFAULT_PERIOD`, `mode` = 0
  - `done`, `running`, `irq_flag` = 0 and `irq` = 0
  - prescaler = 0
- Without prescale, a start sampled at edge E0 gives `done` high in the cycle following edge E(period+1). The interval is `period+1` clocks; periodic pulses are spaced `period+1` clocks apart.
- `running` rises in the cycle after `start` is sampled. In one-shot mode it falls in the same cycle that `done` rises.
- `irq` follows `irq_flag` combinationally, so it rises in the same cycle as `done`.
- An asynchronous reset mid-count returns the channel to IDLE immediately. No `done` is produced.

## Configuration
- `TIMER_BANK_PRESCALE_EN` defined:
  - A single shared free-running prescaler counts 0..PRESCALE-1 and produces a one-cycle tick at PRESCALE-1.
  - Counting and terminal detection occur only on tick cycles. The interval is (period+1)×PRESCALE clocks, with the phase set by the free-running prescaler.
  - start, stop, pause, load and irq logic still act every clock.
- Not defined: tick is tied to 1, no prescaler logic is instantiated, and one count occurs per clock.

## Test plan
- **One-shot:** ch0 `period`=9, `periodic`=0, start at cycle 0 -> single `done[0]` pulse at cycle 11, `running[0]` low from cycle 11, `irq_flag[0]`=1.
- **Periodic:** ch1 `period`=4, `periodic`=1 -> `done[1]` pulses at cycles 6, 11, 16. Load 9 mid-run -> spacing changes to 10 after the next pulse.
- **Stop and collisions:** stop ch2 at `count`=3 -> IDLE, no `done`. Start and stop in the same cycle -> IDLE. Stop in the terminal cycle -> no `done`.
- **Pause:** ch3 `period`=9, `pause` high for 5 cycles starting at `count`=4 -> `done` delayed by exactly 5 cycles (cycle 16). Pause in the terminal cycle -> `done` still fires.
- **Interrupt:** `irq_en`=0 -> `irq`=0 while `irq_flag`=1. `irq_clr` asserted on a `done` cycle -> flag stays 1. Async reset mid-run -> all outputs 0.
- **Prescale (`TIMER_BANK_PRESCALE_EN`, PRESCALE=4):** period=2 periodic -> `done` pulses spaced 12 clocks apart.
